// File: rtl/if_stage_if.sv
// Handshake and data bundle between pre-IF, the ICache return path, the
// IF stage and the ID stage.
interface if_stage_if;
    logic [31:0] ps_to_fs_bus;
    logic        ps_req_fire;
    logic        ps_adel;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ds_allowin;
    logic        flush;
    logic        fs_allowin;
    logic [31:0] fs_pc;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;

    modport master (
        output ps_to_fs_bus, ps_req_fire, ps_adel, inst_data_ok, inst_rdata,
               ds_allowin, flush,
        input  fs_allowin, fs_pc, fs_to_ds_valid, fs_to_ds_bus
    );

    modport slave (
        input  ps_to_fs_bus, ps_req_fire, ps_adel, inst_data_ok, inst_rdata,
               ds_allowin, flush,
        output fs_allowin, fs_pc, fs_to_ds_valid, fs_to_ds_bus
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: in-order reservation queue pairing ICache returns
// with their PCs, dropping returns of requests cancelled by a flush.
module if_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'hbfbffffc
) (
    input  logic     clk,
    input  logic     resetn,
    if_stage_if.slave fs
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] done_r;
    logic [DEPTH-1:0] adel_r;
    logic [31:0]      pc_r   [DEPTH];
    logic [31:0]      inst_r [DEPTH];
    ptr_t             head_r;
    ptr_t             tail_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    cancel_r;
    logic [31:0]      fs_pc_r;

    logic          allowin_s;
    logic          alloc_s;
    logic          pop_s;
    logic          fill_s;
    logic          pend_any_s;
    ptr_t          fill_idx_s;
    ptr_t          wr_idx_s;
    logic [CW-1:0] pend_cnt_s;
    logic [CW:0]   cancel_sum_s;
    logic [CW-1:0] flush_cancel_s;

    // Handshake decode and outputs taken straight from the head entry
    always_comb begin
        allowin_s         = (count_r < DEPTH_C);
        alloc_s           = (fs.ps_req_fire | fs.ps_adel) & allowin_s;
        fs.fs_allowin     = allowin_s;
        fs.fs_pc          = fs_pc_r;
        fs.fs_to_ds_valid = vld_r[head_r] & done_r[head_r];
        fs.fs_to_ds_bus   = {adel_r[head_r], pc_r[head_r], inst_r[head_r]};
        pop_s             = vld_r[head_r] & done_r[head_r] & fs.ds_allowin & ~fs.flush;
        // The redirect allocated during a flush lands in slot 0 of the emptied queue
        wr_idx_s          = fs.flush ? ptr_t'(0) : tail_r;
    end

    // Oldest pending entry (fill target) and number of pending entries
    always_comb begin
        pend_any_s = 1'b0;
        fill_idx_s = head_r;
        pend_cnt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_s = pend_cnt_s + CW'(vld_r[i] & ~done_r[i]);
            if (!pend_any_s && vld_r[head_r + ptr_t'(i)] && !done_r[head_r + ptr_t'(i)]) begin
                pend_any_s = 1'b1;
                fill_idx_s = head_r + ptr_t'(i);
            end else begin
                pend_any_s = pend_any_s;
            end
        end
        fill_s = fs.inst_data_ok & (cancel_r == '0) & pend_any_s;
    end

    // Cancel count after a flush: returns still owed, less the one arriving now
    always_comb begin
        cancel_sum_s = (CW+1)'(cancel_r) + (CW+1)'(pend_cnt_s);
        if (fs.inst_data_ok && (cancel_sum_s != '0)) begin
            cancel_sum_s = cancel_sum_s - (CW+1)'(1);
        end else begin
            cancel_sum_s = cancel_sum_s;
        end
        // Saturate so that repeated flushes cannot wrap the counter
        if (cancel_sum_s[CW]) begin
            flush_cancel_s = '1;
        end else begin
            flush_cancel_s = cancel_sum_s[CW-1:0];
        end
    end

    // Queue state, pointers, cancel counter and fs_pc
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_r    <= '0;
            done_r   <= '0;
            adel_r   <= '0;
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            cancel_r <= '0;
            fs_pc_r  <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]   <= 32'h0000_0000;
                inst_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (fs.flush) begin
                vld_r    <= '0;
                head_r   <= '0;
                tail_r   <= alloc_s ? ptr_t'(1) : ptr_t'(0);
                count_r  <= alloc_s ? CW'(1) : CW'(0);
                cancel_r <= flush_cancel_s;
            end else begin
                if (pop_s) begin
                    vld_r[head_r] <= 1'b0;
                    head_r        <= head_r + ptr_t'(1);
                end
                if (alloc_s) begin
                    tail_r <= tail_r + ptr_t'(1);
                end
                count_r <= count_r + CW'(alloc_s) - CW'(pop_s);
                if (fs.inst_data_ok && (cancel_r != '0)) begin
                    cancel_r <= cancel_r - CW'(1);
                end
                if (fill_s) begin
                    done_r[fill_idx_s] <= 1'b1;
                    inst_r[fill_idx_s] <= fs.inst_rdata;
                end
            end
            // A misaligned PC is complete at allocation and never reaches the ICache
            if (alloc_s) begin
                vld_r[wr_idx_s]  <= 1'b1;
                done_r[wr_idx_s] <= fs.ps_adel;
                adel_r[wr_idx_s] <= fs.ps_adel;
                pc_r[wr_idx_s]   <= fs.ps_to_fs_bus;
                inst_r[wr_idx_s] <= 32'h0000_0000;
                fs_pc_r          <= fs.ps_to_fs_bus;
            end
        end
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly downstream of the pre-IF stage.
- Tracks every instruction request the pre-IF stage has accepted by the ICache (inst_valid & inst_addr_ok) in a small in-order reservation queue.
- Pairs each returned inst_data_ok/inst_rdata with its PC, then presents instructions in order to the ID stage with a valid/allowin handshake.
- Drops returns belonging to requests that were in flight when a flush occurred. Supplies fs_pc and fs_allowin back to pre-IF.

Parameters:
- DEPTH, 2, reservation-queue entries, which is also the maximum number of requests in flight plus instructions held. Must be a power of 2 and at least 2.
- RESET_PC, 32'hbfbffffc, fs_pc reset value, chosen so that the pre-IF seq_pc (fs_pc+4) = 32'hbfc00000.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous reset, active low.
- ps_to_fs_bus  in  32  nextpc of the request being issued this cycle.
- ps_req_fire  in  1  request accepted by ICache this cycle (inst_valid & inst_addr_ok).
- ps_adel  in  1  nextpc misaligned (nextpc[1:0]!=0) while fs_allowin=1; no ICache request is issued.
- inst_data_ok  in  1  one instruction returned this cycle; returns are in request order.
- inst_rdata  in  32  returned instruction word.
- ds_allowin  in  1  ID stage can accept this cycle.
- flush  in  1  exception or eret redirect; discards all queued work.
- fs_allowin  out  1  pre-IF may issue a request or an adel allocation this cycle.
- fs_pc  out  32  PC of the most recently allocated entry.
- fs_to_ds_valid  out  1  head entry is complete and presented to ID.
- fs_to_ds_bus  out  65  {adel_ex[64], pc[63:32], inst[31:0]} of the head entry.

Behaviour:
- Queue entry fields: vld, done, adel, pc[31:0], inst[31:0]. Pointers head, tail, and fill (the oldest entry with vld & ~done) wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset (resetn=0, asynchronous):
  - all vld=0, pointers=0, count=0, cancel_cnt=0.
  - fs_pc=RESET_PC, fs_to_ds_valid=0, fs_to_ds_bus=0, fs_allowin=1.
- fs_allowin = (count<DEPTH). It is combinational and does not credit a same-cycle pop.
- Allocate on (ps_req_fire|ps_adel) & fs_allowin:
  - tail entry gets vld=1, pc=ps_to_fs_bus, adel=ps_adel.
  - ps_adel gives done=1, inst=0. A plain request gives done=0.
  - fs_pc <= ps_to_fs_bus on the next edge. If ps_req_fire and ps_adel are both 1, adel wins.
- Fill on inst_data_ok:
  - cancel_cnt>0: the return is discarded and cancel_cnt decrements.
  - otherwise: entry[fill] gets done=1, inst=inst_rdata.
  - inst_data_ok with cancel_cnt=0 and no pending entry is a protocol error, ignored (assertion in bench).
- Output:
  - fs_to_ds_valid = vld&done of head, combinational from registers with no extra latency.
  - A return at edge N is visible at ID from cycle N+1.
- Pop: fs_to_ds_valid & ds_allowin & ~flush at an edge frees the head; head++.
- Same-cycle events:
  - allocate, fill and pop in one cycle are all legal. count changes by alloc-pop.
  - A fill may complete the entry being popped only from the next cycle; no bypass from inst_rdata to fs_to_ds_bus.
- Flush (sampled at edge):
  - all vld<=0 and count<=0.
  - cancel_cnt <= cancel_cnt + (number of vld&~done entries) - (inst_data_ok ? 1 : 0), using pre-flush values. This cancels the return arriving in the flush cycle.
  - fs_to_ds_valid is 0 from the next cycle, and no pop occurs in the flush cycle.
  - An allocation in the flush cycle (the redirect request) is kept as entry 0 of the emptied queue: head=0, tail=1.
  - fs_pc takes the redirect PC.
- cancel_cnt width is clog2(DEPTH)+1. It can reach DEPTH. Further flushes while it is non-zero must not overflow it.
- Ordering: returns are strictly in order, so cancelled returns always precede the redirected instruction.
- Reset mid-operation: asynchronous clear of all state as above. Outstanding ICache returns after reset are the ICache's responsibility and are not cancelled.

Test Plan:
- Sequential fetch:
  - Stimulus: resetn release, requests 32'hbfc00000 then 32'hbfc00004, data_ok one cycle after each, ds_allowin=1.
  - Required: fs_pc=32'hbfbffffc at reset, then two bus beats {0,bfc00000,I0} and {0,bfc00004,I1} in order.
- Backpressure:
  - Stimulus: ds_allowin=0 with 2 requests returned.
  - Required: fs_allowin=0 and the head is held stable. Raise ds_allowin: both pop in consecutive cycles, and fs_allowin=1 the cycle after the first pop.
- Flush with 2 in flight:
  - Stimulus: flush with 2 pending, plus a redirect request to 32'hbfc00380 the same cycle.
  - Required: the next 2 data_ok are dropped. The third returns as {0,bfc00380,Ix}, and fs_to_ds_valid never shows a stale PC.
- Flush coinciding with data_ok:
  - Stimulus: 2 pending, flush and data_ok in the same cycle.
  - Required: cancel_cnt=1, and exactly one later return is dropped.
- Misaligned PC:
  - Stimulus: ps_adel with ps_to_fs_bus=32'h00400002.
  - Required: the entry completes immediately and ID sees {1,00400002,0} one cycle later with no ICache traffic.
- Asynchronous reset pulse with the queue full:
  - Required: outputs return to reset values without a clock edge.
